// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a_in, b_in, cin_in,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a_in, b_in, cin_in,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per operation.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last completed result
// RUN   | one bit per edge through the full-adder cell
// DONE  | one-cycle done pulse, then back to IDLE
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    bit_cnt;

   logic fa_s;
   logic fa_c;

   assign fa_s = shift_a[0] ^ shift_b[0] ^ carry;
   assign fa_c = (shift_a[0] & shift_b[0]) | (carry & (shift_a[0] ^ shift_b[0]));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shift_a  <= '0;
         shift_b  <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         bit_cnt  <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
         bus.ovf  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shift_a  <= bus.a_in;
                  shift_b  <= bus.b_in;
                  carry    <= bus.cin_in;
                  acc      <= '0;
                  bit_cnt  <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               shift_a <= shift_a >> 1;
               shift_b <= shift_b >> 1;
               carry   <= fa_c;
               acc     <= {fa_s, acc[WIDTH-1:1]};
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  // acc stays private so partial sums never reach the output
                  bus.sum  <= {fa_s, acc[WIDTH-1:1]};
                  bus.cout <= fa_c;
                  bus.ovf  <= carry ^ fa_c;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bit_cnt  <= '0;
                  state    <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 (directed + random) and WIDTH=16 (random).
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [9:0]  q8[$];
   logic [17:0] q16[$];
   logic [7:0]  last8;

   serial_adder_if #(.WIDTH(8))  i8();
   serial_adder_if #(.WIDTH(16)) i16();

   serial_adder_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
   serial_adder_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // {ovf, cout, sum}
   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] s;
      logic       v;
      s = {1'b0, a} + {1'b0, b} + {8'd0, c};
      v = (a[7] == b[7]) && (s[7] != a[7]);
      return {v, s[8], s[7:0]};
   endfunction

   function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] s;
      logic        v;
      s = {1'b0, a} + {1'b0, b} + {16'd0, c};
      v = (a[15] == b[15]) && (s[15] != a[15]);
      return {v, s[16], s[15:0]};
   endfunction

   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst) begin
         check("excl8", i8.busy & i8.done, 0);
         if (i8.done) begin
            if (q8.size() == 0) begin
               check("spurious_done8", i8.done, 0);
            end else begin
               e = q8.pop_front();
               check("sum8", i8.sum, e[7:0]);
               check("cout8", i8.cout, e[8]);
               check("ovf8", i8.ovf, e[9]);
               last8 = e[7:0];
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [17:0] e;
      if (!rst) begin
         check("excl16", i16.busy & i16.done, 0);
         if (i16.done) begin
            if (q16.size() == 0) begin
               check("spurious_done16", i16.done, 0);
            end else begin
               e = q16.pop_front();
               check("sum16", i16.sum, e[15:0]);
               check("cout16", i16.cout, e[16]);
               check("ovf16", i16.ovf, e[17]);
            end
         end
      end
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit inj);
      int n;
      @(negedge clk);
      i8.a_in   = a;
      i8.b_in   = b;
      i8.cin_in = c;
      i8.start  = 1'b1;
      q8.push_back(model8(a, b, c));
      @(negedge clk);
      i8.start  = 1'b0;
      i8.a_in   = ~a;
      i8.b_in   = 8'($urandom);
      i8.cin_in = ~c;
      n = 0;
      while (i8.busy && n < 40) begin
         n++;
         check("hold_sum8", i8.sum, last8);
         if (inj && n == 3) begin
            i8.start = 1'b1;
            i8.a_in  = 8'hFF;
            i8.b_in  = 8'hFF;
         end else begin
            i8.start = 1'b0;
         end
         @(negedge clk);
      end
      check("busy_len8", n, 8);
      check("done8", i8.done, 1);
      if (inj) i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      check("idle_after8", {i8.busy, i8.done}, 0);
      @(negedge clk);
      check("no_reload8", i8.busy, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nops;
      checks    = 0;
      errors    = 0;
      last8     = 8'h00;
      rst       = 1'b1;
      i8.start  = 1'b0;
      i8.a_in   = '0;
      i8.b_in   = '0;
      i8.cin_in = 1'b0;
      i16.start  = 1'b0;
      i16.a_in   = '0;
      i16.b_in   = '0;
      i16.cin_in = 1'b0;
      i8.start  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", i8.busy, 0);
      check("rst_done", i8.done, 0);
      check("rst_sum", i8.sum, 0);
      check("rst_cout_ovf", {i8.cout, i8.ovf}, 0);
      check("rst_busy16", i16.busy, 0);
      i8.start = 1'b0;
      rst = 1'b0;

      op8(8'h5A, 8'h3C, 1'b0, 1'b0);
      op8(8'hFF, 8'h01, 1'b0, 1'b0);
      op8(8'hFF, 8'hFF, 1'b1, 1'b0);
      op8(8'h80, 8'h80, 1'b0, 1'b0);
      op8(8'h7F, 8'h00, 1'b1, 1'b0);
      op8(8'h12, 8'h34, 1'b0, 1'b1);

      // abort mid-RUN: no result may be produced for this operation
      @(negedge clk);
      i8.a_in  = 8'hAA;
      i8.b_in  = 8'h55;
      i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_abort_busy", i8.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", i8.busy, 0);
      check("abort_sum", i8.sum, 0);
      check("abort_done", i8.done, 0);
      last8 = 8'h00;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_idle", i8.busy, 0);
      op8(8'h01, 8'h02, 1'b0, 1'b0);

      nops = 20;
      @(negedge clk);
      i8.a_in   = 8'($urandom);
      i8.b_in   = 8'($urandom);
      i8.cin_in = 1'($urandom);
      i8.start  = 1'b1;
      q8.push_back(model8(i8.a_in, i8.b_in, i8.cin_in));
      for (int k = 0; k < nops; k++) begin
         n = 0;
         while (!i8.done && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("rdone8", i8.done, 1);
         #1;
         if (k < nops - 1) begin
            i8.a_in   = 8'($urandom);
            i8.b_in   = 8'($urandom);
            i8.cin_in = 1'($urandom);
            q8.push_back(model8(i8.a_in, i8.b_in, i8.cin_in));
         end else begin
            i8.start = 1'b0;
         end
         @(negedge clk);
         check("rgap8", {i8.busy, i8.done}, 0);
         if (k < nops - 1) begin
            @(negedge clk);
            check("racc8", i8.busy, 1);
         end
      end
      repeat (3) @(negedge clk);
      check("q8_empty", q8.size(), 0);

      @(negedge clk);
      i16.a_in   = 16'($urandom);
      i16.b_in   = 16'($urandom);
      i16.cin_in = 1'($urandom);
      i16.start  = 1'b1;
      q16.push_back(model16(i16.a_in, i16.b_in, i16.cin_in));
      for (int k = 0; k < nops; k++) begin
         n = 0;
         while (!i16.done && n < 60) begin
            @(negedge clk);
            n++;
         end
         check("rdone16", i16.done, 1);
         #1;
         if (k < nops - 1) begin
            i16.a_in   = 16'($urandom);
            i16.b_in   = 16'($urandom);
            i16.cin_in = 1'($urandom);
            q16.push_back(model16(i16.a_in, i16.b_in, i16.cin_in));
         end else begin
            i16.start = 1'b0;
         end
         @(negedge clk);
         check("rgap16", {i16.busy, i16.done}, 0);
         if (k < nops - 1) begin
            @(negedge clk);
            check("racc16", i16.busy, 1);
         end
      end
      repeat (3) @(negedge clk);
      check("q16_empty", q16.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; samples a_in, b_in and cin_in when accepted.
REQ-005 a_in  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 b_in  input  WIDTH  operand B.
REQ-007 cin_in  input  1  carry-in to bit 0.
REQ-008 busy  output  1  high while an addition is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  registered result A+B+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The block SHALL add bit-serially, LSB first, through one full-adder cell (a, b, carry -> sum bit, carry) per cycle.
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL encode no others. An unreachable encoding SHALL return to IDLE on the next edge.
REQ-015 IDLE: start=1 at an edge SHALL load shift_a<=a_in, shift_b<=b_in, carry<=cin_in and bit_cnt<=0, and SHALL move to RUN. start=0 SHALL keep the block in IDLE.
REQ-016 RUN: each edge SHALL feed shift_a[0], shift_b[0] and carry to the adder cell, shift the sum bit into the result register MSB-side (shift right), shift shift_a and shift_b right by one, update carry, and increment bit_cnt.
REQ-017 RUN: the edge with bit_cnt==WIDTH-1 SHALL complete the last bit, capture cout and ovf, and move to DONE.
REQ-018 DONE: done SHALL be 1 for exactly this one cycle, and the next edge SHALL move to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge E0, busy SHALL be 1 in the cycles after edges E0..E0+WIDTH-1, and done SHALL be 1 in the cycle after edge E0+WIDTH.
REQ-020 start SHALL be ignored in RUN and DONE: no reload and no effect on the in-flight result.
REQ-021 a_in, b_in and cin_in SHALL be sampled only at the accepting edge. Changes during RUN SHALL NOT affect the result.
REQ-022 sum, cout and ovf SHALL hold their last completed values from done until the edge after the next accepted start.
REQ-023 Intermediate partial sums SHALL NOT appear on sum before done.
REQ-024 bit_cnt width SHALL be clog2(WIDTH). The counter SHALL NOT wrap within an operation.
REQ-025 busy and done SHALL never be 1 in the same cycle.

Reset
REQ-026 rst=1 at an edge SHALL force: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers=0, carry=0, bit_cnt=0.
REQ-027 rst SHALL take priority over start and over any state transition.
REQ-028 rst asserted mid-RUN SHALL abort the operation. No done SHALL be produced for the aborted operation.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 WIDTH=8: a=0x5A, b=0x3C, cin=0 -> after 9 cycles done=1, sum=0x96, cout=0, ovf=1; busy high for exactly 8 cycles.
REQ-031 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-032 WIDTH=8: a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-033 Start a=0x12, b=0x34, then pulse start with a=0xFF, b=0xFF at RUN cycle 3 and again in the DONE cycle -> single done, sum=0x46, cout=0; block returns to IDLE.
REQ-034 Start an operation, assert rst at RUN cycle 4 -> next cycle busy=0, sum=0, no done. Then start a=0x01, b=0x02 -> done after 9 cycles with sum=0x03.
REQ-035 Randomized back-to-back starts (start held high) at WIDTH=8 and WIDTH=16 -> each result equals a+b+cin against a reference model, with one done per accepted start and one idle cycle between done and the next acceptance.
